// File: rtl/mux_8_1_rr_sched_v_pkg.sv
// Shared constants, state encoding and round-robin winner search for the
// 8-requester channel scheduler.
package mux_8_1_rr_sched_v_pkg;

  localparam int unsigned SEL_W = 3;
  localparam int unsigned N_REQ = 8;
  localparam int unsigned CNT_W = 4;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  typedef struct packed {
    logic             found;
    logic [SEL_W-1:0] idx;
  } win_t;

  // Search ptr+1, ptr+2, ... ptr with natural 3-bit wrap; ptr itself is last.
  function automatic win_t next_winner(input logic [N_REQ-1:0] req,
                                       input logic [SEL_W-1:0] ptr);
    win_t             w;
    logic [SEL_W-1:0] idx;
    w = '0;
    for (int i = 1; i <= int'(N_REQ); i++) begin
      idx = ptr + SEL_W'(i);
      if (!w.found && req[idx]) begin
        w.found = 1'b1;
        w.idx   = idx;
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/mux_8_1_rr_sched_v_mux.sv
// Behavioural 8:1 single-bit mux with enable; output is 0 when disabled.
module MUX_8_1_v__behavior
  import mux_8_1_rr_sched_v_pkg::*;
(
  input  logic             i_en,
  input  logic [N_REQ-1:0] i_code,
  input  logic [SEL_W-1:0] i_sel,
  output logic             o_f
);

  assign o_f = i_en ? i_code[i_sel] : 1'b0;

endmodule

// File: rtl/mux_8_1_rr_sched_v.sv
// Round-robin scheduler granting one of eight requesters the shared 8:1 mux
// channel for bursts of at most BURST_LEN cycles.
module mux_8_1_rr_sched_v
  import mux_8_1_rr_sched_v_pkg::*;
#(
  parameter int unsigned BURST_LEN = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic [N_REQ-1:0] i_req,
  input  logic [N_REQ-1:0] i_code,
  output logic [N_REQ-1:0] o_gnt,
  output logic [SEL_W-1:0] o_sel_code,
  output logic             o_busy,
  output logic             o_f
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_LEN - 1);

  logic [0:0]       state_q, state_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic             mux_f;
  win_t             win;

  // In GRANT ptr_q always equals the owner, so one search covers both the
  // first grant from IDLE and the hand-off starting at owner+1.
  assign win = next_winner(i_req, ptr_q);

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path infers a latch.
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (i_en && win.found) begin
          state_d        = ST_GRANT;
          ptr_d          = win.idx;
          sel_d          = win.idx;
          cnt_d          = '0;
          gnt_d          = '0;
          gnt_d[win.idx] = 1'b1;
        end
      end
      default: begin
        if (i_en && i_req[sel_q] && (cnt_q < CNT_LAST)) begin
          cnt_d = cnt_q + 1'b1;
        end else if (i_en && win.found) begin
          // Owner's own request is searched last, so it is re-granted only
          // when nobody else is waiting at burst expiry.
          ptr_d          = win.idx;
          sel_d          = win.idx;
          cnt_d          = '0;
          gnt_d          = '0;
          gnt_d[win.idx] = 1'b1;
        end else begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          gnt_d   = '0;
        end
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values computed above.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '1;
      sel_q   <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
    end
  end

  assign o_gnt      = gnt_q;
  assign o_sel_code = sel_q;
  assign o_busy     = (state_q == ST_GRANT);

  MUX_8_1_v__behavior u_mux (
    .i_en   (o_busy),
    .i_code (i_code),
    .i_sel  (sel_q),
    .o_f    (mux_f)
  );

  assign o_f = mux_f & o_busy;

endmodule

// File: tb/tb_mux_8_1_rr_sched_v.sv
// Scoreboard bench for the round-robin channel scheduler: directed vectors push
// hand-computed expectations, a monitor pops and compares after each edge.
module tb_mux_8_1_rr_sched_v;

  typedef struct packed {
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       busy;
    logic       f;
  } obs_t;

  typedef struct packed {
    logic [15:0] tag;
    obs_t        obs;
  } item_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] req;
  logic [7:0] code;
  logic [7:0] gnt;
  logic [2:0] sel;
  logic       busy;
  logic       f;

  item_t sb_q[$];
  int    total = 0;
  int    bad   = 0;
  int    n_tag = 0;
  event  probe_ev;

  mux_8_1_rr_sched_v #(.BURST_LEN(4)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_en       (en),
    .i_req      (req),
    .i_code     (code),
    .o_gnt      (gnt),
    .o_sel_code (sel),
    .o_busy     (busy),
    .o_f        (f)
  );

  always #5 clk = ~clk;

  task automatic check(input logic [15:0] tag, input obs_t act, input obs_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL vec%0d: got gnt=%h sel=%0d busy=%b f=%b, want gnt=%h sel=%0d busy=%b f=%b",
               tag, act.gnt, act.sel, act.busy, act.f, exp.gnt, exp.sel, exp.busy, exp.f);
    end
  endtask

  function automatic item_t mk(input logic [7:0] g, input logic [2:0] s,
                               input logic b, input logic ff);
    item_t it;
    it.tag      = 16'(n_tag);
    it.obs.gnt  = g;
    it.obs.sel  = s;
    it.obs.busy = b;
    it.obs.f    = ff;
    return it;
  endfunction

  // Apply inputs for the coming edge, queue the post-edge expectation, then
  // advance to just after the following falling edge.
  task automatic step(input logic e, input logic [7:0] r, input logic [7:0] c,
                      input logic [7:0] g, input logic [2:0] s,
                      input logic b, input logic ff);
    en   = e;
    req  = r;
    code = c;
    sb_q.push_back(mk(g, s, b, ff));
    n_tag++;
    @(negedge clk);
    #1;
  endtask

  task automatic probe(input logic [7:0] g, input logic [2:0] s,
                       input logic b, input logic ff);
    sb_q.push_back(mk(g, s, b, ff));
    n_tag++;
    -> probe_ev;
    #2;
  endtask

  // Monitor: after every rising edge (or an asynchronous probe) compare the
  // outputs against the oldest pending expectation.
  initial begin
    item_t it;
    obs_t  act;
    forever begin
      @(posedge clk or probe_ev);
      #1;
      if (sb_q.size() > 0) begin
        it   = sb_q.pop_front();
        act  = '{gnt: gnt, sel: sel, busy: busy, f: f};
        check(it.tag, act, it.obs);
      end
    end
  end

  initial begin
    int          owner;
    logic [7:0]  c;
    rst  = 1'b1;
    en   = 1'b1;
    req  = 8'hFF;
    code = 8'h00;
    #12;
    probe(8'h00, 3'd0, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    rst = 1'b0;

    // Full rotation 0..7 then back to 0, four cycles each; 0xAA makes f = owner[0].
    for (int cyc = 0; cyc < 36; cyc++) begin
      owner = (cyc / 4) % 8;
      step(1'b1, 8'hFF, 8'hAA, 8'h01 << owner, 3'(owner), 1'b1, owner[0]);
    end
    step(1'b1, 8'h00, 8'hAA, 8'h00, 3'd0, 1'b0, 1'b0);

    // Lone requester 5: continuous grant across burst re-grants, f tracks code[5].
    for (int j = 0; j < 10; j++) begin
      c = (j % 2 == 1) ? 8'h20 : 8'h00;
      step(1'b1, 8'h20, c, 8'h20, 3'd5, 1'b1, c[5]);
    end

    // Owner 2 drops after one cycle; 6 takes over with no idle gap.
    step(1'b1, 8'h00, 8'h00, 8'h00, 3'd5, 1'b0, 1'b0);
    step(1'b1, 8'h04, 8'hFF, 8'h04, 3'd2, 1'b1, 1'b1);
    step(1'b1, 8'h40, 8'hFF, 8'h40, 3'd6, 1'b1, 1'b1);
    step(1'b1, 8'h40, 8'h00, 8'h40, 3'd6, 1'b1, 1'b0);

    // Enable low mid-burst releases, blocks grants, then resumes at ptr+1.
    step(1'b0, 8'h40, 8'hFF, 8'h00, 3'd6, 1'b0, 1'b0);
    step(1'b0, 8'hFF, 8'hFF, 8'h00, 3'd6, 1'b0, 1'b0);
    step(1'b1, 8'hFF, 8'hFF, 8'h80, 3'd7, 1'b1, 1'b1);

    // Wrap-around from ptr=7: 0 first, then 7 at expiry although 0 still asks.
    step(1'b1, 8'h00, 8'hFF, 8'h00, 3'd7, 1'b0, 1'b0);
    for (int j = 0; j < 4; j++)
      step(1'b1, 8'h81, 8'hFF, 8'h01, 3'd0, 1'b1, 1'b1);
    step(1'b1, 8'h81, 8'hFF, 8'h80, 3'd7, 1'b1, 1'b1);
    step(1'b1, 8'h81, 8'hFF, 8'h80, 3'd7, 1'b1, 1'b1);

    // Asynchronous reset between edges mid-burst, with all data lines high.
    rst = 1'b1;
    #1;
    probe(8'h00, 3'd0, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    rst = 1'b0;
    step(1'b1, 8'h81, 8'hFF, 8'h01, 3'd0, 1'b1, 1'b1);

    for (int k = 0; k < 10 && sb_q.size() > 0; k++)
      @(negedge clk);
    if (sb_q.size() > 0) begin
      bad++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
